match_sequencer: RTL

// - Top-level game controller for the two-player air-hockey datapath.
// - Sequences SPLASH -> PLAY -> GOAL -> PLAY/END, detects goals from the puck position and keeps the score.
// - Drives the 2-bit state consumed by the VGA renderer and the object reset consumed by the paddle/puck updaters.
// - Sits beside the renderer in the clk domain; all inputs arrive synchronous to clk except start_btn.

---
 rtl/game_pkg.sv | 38 +++
 rtl/btn_sync_edge.sv | 40 ++++
 rtl/match_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Package     : game_pkg
// Description : Shared definitions for the air-hockey game controller and
//               the VGA renderer: state codes, winner codes and the default
//               goal-mouth geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  // 2-bit state code seen by the renderer.
  localparam logic [1:0] ST_SPLASH = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_END    = 2'd2;
  localparam logic [1:0] ST_GOAL   = 2'd3;

  // Winner codes, meaningful while in ST_END.
  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  // Default match rules and goal-mouth geometry (screen coordinates).
  localparam int unsigned WIN_SCORE_DEF   = 5;
  localparam int unsigned PAUSE_TICKS_DEF = 60;
  localparam int unsigned GOAL_LX_DEF     = 224;
  localparam int unsigned GOAL_RX_DEF     = 704;
  localparam int unsigned GOAL_YLO_DEF    = 246;
  localparam int unsigned GOAL_YHI_DEF    = 296;

  // True when a y coordinate lies inside the goal mouth, both bounds inclusive.
  function automatic logic in_goal_window(input logic [9:0] y,
                                          input logic [9:0] lo,
                                          input logic [9:0] hi);
    return (y >= lo) && (y <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : btn_sync_edge
// Description : Two-flop synchroniser for an asynchronous button level,
//               followed by a registered rising-edge detector. The pulse is
//               one clk wide and appears on the third clk edge after the
//               input edge; a held button yields exactly one pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_sync_edge (
  input  logic clk,
  input  logic clr,
  input  logic btn_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;

  // Synchronise the button, remember the previous level and register the edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/match_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : match_sequencer
// Description : Air-hockey game controller. Sequences SPLASH -> PLAY ->
//               GOAL -> PLAY/END, detects goals from the puck position,
//               keeps the score and drives the renderer state and the
//               paddle/puck home-position hold.
//               Optional macro MATCH_SEQUENCER_HIT_COUNT_EN adds saturating
//               paddle-hit counters; without it hits1/hits2 are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module match_sequencer
  import game_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF,
  parameter int unsigned PAUSE_TICKS = PAUSE_TICKS_DEF,
  parameter int unsigned GOAL_LX     = GOAL_LX_DEF,
  parameter int unsigned GOAL_RX     = GOAL_RX_DEF,
  parameter int unsigned GOAL_YLO    = GOAL_YLO_DEF,
  parameter int unsigned GOAL_YHI    = GOAL_YHI_DEF
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic [9:0] puck_x,
  input  logic [9:0] puck_y,
  input  logic       collide1,
  input  logic       collide2,
  output logic [1:0] state,
  output logic       rst_obj,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [7:0] hits1,
  output logic [7:0] hits2
);

  localparam logic [3:0] c_WIN_SCORE = 4'(WIN_SCORE);
  localparam logic [7:0] c_PAUSE     = 8'(PAUSE_TICKS);
  localparam logic [9:0] c_GOAL_LX   = 10'(GOAL_LX);
  localparam logic [9:0] c_GOAL_RX   = 10'(GOAL_RX);
  localparam logic [9:0] c_GOAL_YLO  = 10'(GOAL_YLO);
  localparam logic [9:0] c_GOAL_YHI  = 10'(GOAL_YHI);

  logic [1:0] state_q,  state_d;
  logic       rst_obj_q, rst_obj_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] pause_q,  pause_d;

  logic w_start_rise;
  logic w_in_y;
  logic w_goal_l;
  logic w_goal_r;
  logic w_splash_exit;

  btn_sync_edge u_start_sync (
    .clk    (clk),
    .clr    (clr),
    .btn_i  (start_btn),
    .rise_o (w_start_rise)
  );

  assign w_in_y        = in_goal_window(puck_y, c_GOAL_YLO, c_GOAL_YHI);
  assign w_goal_l      = (puck_x <= c_GOAL_LX) && w_in_y;
  assign w_goal_r      = (puck_x >= c_GOAL_RX) && w_in_y;
  assign w_splash_exit = (state_q == ST_SPLASH) && w_start_rise;

  // State and score registers; clr aborts to the idle splash screen at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_SPLASH;
      rst_obj_q <= 1'b1;
      score1_q  <= 4'd0;
      score2_q  <= 4'd0;
      winner_q  <= WIN_NONE;
      pause_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      rst_obj_q <= rst_obj_d;
      score1_q  <= score1_d;
      score2_q  <= score2_d;
      winner_q  <= winner_d;
      pause_q   <= pause_d;
    end
  end

  // Next-state logic: match sequencing, goal scoring and the post-goal pause.
  always_comb begin
    state_d  = state_q;
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;
    pause_d  = pause_q;
    case (state_q)
      ST_SPLASH: begin
        if (w_start_rise) begin
          state_d  = ST_PLAY;
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = WIN_NONE;
        end
      end
      ST_PLAY: begin
        // The right mouth takes priority if both zones ever overlap.
        if (frame_tick && (w_goal_l || w_goal_r)) begin
          state_d = ST_GOAL;
          pause_d = c_PAUSE;
          if (w_goal_r) begin
            score1_d = score1_q + 4'd1;
          end else begin
            score2_d = score2_q + 4'd1;
          end
        end
      end
      ST_GOAL: begin
        if (frame_tick) begin
          pause_d = pause_q - 8'd1;
          // The counter reaches zero on this tick: resume or finish the match.
          if (pause_q == 8'd1) begin
            if (score1_q == c_WIN_SCORE) begin
              state_d  = ST_END;
              winner_d = WIN_P1;
            end else if (score2_q == c_WIN_SCORE) begin
              state_d  = ST_END;
              winner_d = WIN_P2;
            end else begin
              state_d = ST_PLAY;
            end
          end
        end
      end
      ST_END: begin
        if (w_start_rise) begin
          state_d = ST_SPLASH;
        end
      end
      default: begin
        state_d = ST_SPLASH;
      end
    endcase
    rst_obj_d = (state_d != ST_PLAY);
  end

  // Output logic: every match output comes straight from a register.
  always_comb begin
    state   = state_q;
    rst_obj = rst_obj_q;
    score1  = score1_q;
    score2  = score2_q;
    winner  = winner_q;
  end

`ifdef MATCH_SEQUENCER_HIT_COUNT_EN
  logic       coll1_prev_q;
  logic       coll2_prev_q;
  logic [7:0] hits1_q;
  logic [7:0] hits2_q;

  // Count rising edges of each paddle contact during play, saturating at 255.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      coll1_prev_q <= 1'b0;
      coll2_prev_q <= 1'b0;
      hits1_q      <= 8'd0;
      hits2_q      <= 8'd0;
    end else begin
      coll1_prev_q <= collide1;
      coll2_prev_q <= collide2;
      if (w_splash_exit) begin
        hits1_q <= 8'd0;
        hits2_q <= 8'd0;
      end else if (state_q == ST_PLAY) begin
        if (collide1 && !coll1_prev_q && (hits1_q != 8'hFF)) begin
          hits1_q <= hits1_q + 8'd1;
        end
        if (collide2 && !coll2_prev_q && (hits2_q != 8'hFF)) begin
          hits2_q <= hits2_q + 8'd1;
        end
      end
    end
  end

  assign hits1 = hits1_q;
  assign hits2 = hits2_q;
`else
  // Contact inputs are intentionally unused when hit counting is absent.
  logic w_unused_collide;
  logic w_unused_splash_exit;

  assign w_unused_collide     = collide1 ^ collide2;
  assign w_unused_splash_exit = w_splash_exit;
  assign hits1 = 8'd0;
  assign hits2 = 8'd0;
`endif

endmodule
`default_nettype wire
